// File: rtl/alu_pkg.sv
// Shared opcode/subcode encodings and the E2 control-register layout for vec_alu_pipe.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_MUL  = 4'b0010;
  localparam logic [3:0] OP_DIV  = 4'b0011;
  localparam logic [3:0] OP_SMEM = 4'b0100;
  localparam logic [3:0] OP_JMP  = 4'b0110;
  localparam logic [3:0] OP_LD   = 4'b0111;
  localparam logic [3:0] OP_MOVL = 4'b1000;
  localparam logic [3:0] OP_MOVH = 4'b1001;
  localparam logic [3:0] OP_VLD  = 4'b1100;
  localparam logic [3:0] OP_VST  = 4'b1101;
  localparam logic [3:0] OP_DOT  = 4'b1110;

  localparam logic [3:0] JC_JZ  = 4'd0;
  localparam logic [3:0] JC_JNZ = 4'd1;
  localparam logic [3:0] JC_JS  = 4'd2;
  localparam logic [3:0] JC_JNS = 4'd3;

  localparam logic [3:0] MEM_LOAD  = 4'd0;
  localparam logic [3:0] MEM_STORE = 4'd1;

  typedef struct packed {
    logic        vld;
    logic [15:0] ins;
    logic        take_jump;
    logic        load;
  } stage_ctl_t;

endpackage

// File: rtl/alu_div_iter.sv
// One-lane restoring divider: one quotient bit per cycle, done after WIDTH steps.
// The first step is taken on the start edge so a full divide spans exactly WIDTH edges.
module alu_div_iter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             clear,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH);

  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] quo, rem, quo_in, rem_in, quo_nxt, rem_nxt;
  logic [WIDTH:0]   trial;
  logic             idle, step;

  assign idle = (cnt == '0);
  assign step = idle ? start : (cnt != LAST);

  // A zero divisor always "fits", giving all-ones quotient and remainder = dividend.
  always_comb begin
    rem_in  = idle ? '0 : rem;
    quo_in  = idle ? dividend : quo;
    trial   = {rem_in, quo_in[WIDTH-1]};
    quo_nxt = {quo_in[WIDTH-2:0], 1'b0};
    rem_nxt = trial[WIDTH-1:0];
    if (trial >= {1'b0, divisor}) begin
      rem_nxt    = WIDTH'(trial - {1'b0, divisor});
      quo_nxt[0] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      quo <= '0;
      rem <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (step) begin
      cnt <= cnt + 1'b1;
      quo <= quo_nxt;
      rem <= rem_nxt;
    end
  end

  assign quotient  = quo;
  assign remainder = rem;
  assign done      = (cnt == LAST);

endmodule

// File: rtl/vec_alu_pipe.sv
// LANES x WIDTH SIMD execute ALU with E1 (compute) and E2 (memory merge) stages.
// Define ALU_ITER_DIV_EN for a multi-cycle restoring divider instead of a combinational one.
module vec_alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int LANES = 4,
  parameter int PC_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [PC_W-1:0]        in_pc,
  input  logic [15:0]            in_ins,
  input  logic [LANES*WIDTH-1:0] in_op1,
  input  logic [LANES*WIDTH-1:0] in_op2,
  input  logic [LANES*WIDTH-1:0] mem_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [15:0]            out_ins,
  output logic [LANES*WIDTH-1:0] out_result,
  output logic [LANES*WIDTH-1:0] out_ovf_mod,
  output logic                   out_take_jump,
  output logic                   busy
);

  localparam int VW = LANES * WIDTH;

  logic             vld_p1;
  logic [15:0]      ins_p1;
  logic [PC_W-1:0]  pc_p1;
  logic [VW-1:0]    op1_p1, op2_p1;
  stage_ctl_t       ctl_p2;
  logic [VW-1:0]    res_p2, ovf_p2;

  logic             e1_done, e1_adv, accept;
  logic [3:0]       opc, sub;
  logic [7:0]       ival;
  logic             is_div;
  logic [WIDTH-1:0] div_q [LANES];
  logic [WIDTH-1:0] div_r [LANES];

  assign opc    = ins_p1[15:12];
  assign sub    = ins_p1[7:4];
  assign ival   = ins_p1[11:4];
  assign is_div = (opc == OP_DIV);

`ifdef ALU_ITER_DIV_EN
  logic [LANES-1:0] div_done;
  for (genvar g = 0; g < LANES; g++) begin : g_div
    alu_div_iter #(.WIDTH(WIDTH)) u_div (
      .clk       (clk),
      .rst       (rst),
      .start     (vld_p1 && is_div),
      .clear     (e1_adv),
      .dividend  (op1_p1[g*WIDTH +: WIDTH]),
      .divisor   (op2_p1[g*WIDTH +: WIDTH]),
      .quotient  (div_q[g]),
      .remainder (div_r[g]),
      .done      (div_done[g])
    );
  end
  assign e1_done = !is_div || (&div_done);
`else
  for (genvar g = 0; g < LANES; g++) begin : g_div
    logic [WIDTH-1:0] dvd, dvs;
    assign dvd      = op1_p1[g*WIDTH +: WIDTH];
    assign dvs      = op2_p1[g*WIDTH +: WIDTH];
    assign div_q[g] = (dvs == '0) ? '1  : dvd / dvs;
    assign div_r[g] = (dvs == '0) ? dvd : dvd % dvs;
  end
  assign e1_done = 1'b1;
`endif

  assign e1_adv   = vld_p1 && e1_done && (!ctl_p2.vld || out_ready);
  assign in_ready = !vld_p1 || e1_adv;
  assign accept   = in_valid && in_ready;

  logic [VW-1:0]      res_c, ovf_c;
  logic               take_c, load_c, cond;
  logic [WIDTH-1:0]   a, b, dot_sum, pc_next;
  logic [2*WIDTH-1:0] prod;

  always_comb begin
    res_c   = '0;
    ovf_c   = '0;
    take_c  = 1'b0;
    load_c  = 1'b0;
    cond    = 1'b0;
    dot_sum = '0;
    pc_next = WIDTH'(pc_p1 + PC_W'(2));
    for (int i = 0; i < LANES; i++) begin
      a       = op1_p1[i*WIDTH +: WIDTH];
      b       = op2_p1[i*WIDTH +: WIDTH];
      prod    = (2*WIDTH)'(a) * (2*WIDTH)'(b);
      dot_sum = dot_sum + prod[WIDTH-1:0];
      case (opc)
        OP_ADD: res_c[i*WIDTH +: WIDTH] = a + b;
        OP_SUB: res_c[i*WIDTH +: WIDTH] = a - b;
        OP_MUL: begin
          res_c[i*WIDTH +: WIDTH] = prod[WIDTH-1:0];
          ovf_c[i*WIDTH +: WIDTH] = prod[2*WIDTH-1:WIDTH];
        end
        OP_DIV: begin
          res_c[i*WIDTH +: WIDTH] = div_q[i];
          ovf_c[i*WIDTH +: WIDTH] = div_r[i];
        end
        OP_DOT: res_c[i*WIDTH +: WIDTH] = prod[WIDTH-1:0];
        OP_SMEM, OP_VLD, OP_VST:
          if (sub == MEM_STORE) res_c[i*WIDTH +: WIDTH] = a;
        default: ;
      endcase
    end
    // Lane-0-only operations overwrite lane 0 after the per-lane pass.
    a = op1_p1[WIDTH-1:0];
    b = op2_p1[WIDTH-1:0];
    case (opc)
      OP_DOT: res_c[WIDTH-1:0] = dot_sum;
      OP_JMP: begin
        case (sub)
          JC_JZ:   cond = (a == '0);
          JC_JNZ:  cond = (a != '0);
          JC_JS:   cond = a[WIDTH-1];
          JC_JNS:  cond = !a[WIDTH-1];
          default: cond = 1'b0;
        endcase
        take_c           = cond;
        res_c[WIDTH-1:0] = cond ? b : pc_next;
      end
      OP_MOVL: res_c[WIDTH-1:0] = WIDTH'(signed'(ival));
      OP_MOVH: res_c[WIDTH-1:0] = (b & WIDTH'(8'hFF)) | WIDTH'({ival, 8'h00});
      OP_LD:   load_c = 1'b1;
      OP_SMEM, OP_VLD, OP_VST: load_c = (sub == MEM_LOAD);
      default: ;
    endcase
  end

  // E1 stage register: operands captured on accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      ins_p1 <= '0;
      pc_p1  <= '0;
      op1_p1 <= '0;
      op2_p1 <= '0;
    end else if (accept) begin
      vld_p1 <= 1'b1;
      ins_p1 <= in_ins;
      pc_p1  <= in_pc;
      op1_p1 <= in_op1;
      op2_p1 <= in_op2;
    end else if (e1_adv) begin
      vld_p1 <= 1'b0;
    end
  end

  // E2 stage register: held while the consumer stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctl_p2 <= '0;
      res_p2 <= '0;
      ovf_p2 <= '0;
    end else if (e1_adv) begin
      ctl_p2 <= '{vld: 1'b1, ins: ins_p1, take_jump: take_c, load: load_c};
      res_p2 <= res_c;
      ovf_p2 <= ovf_c;
    end else if (out_ready) begin
      ctl_p2.vld <= 1'b0;
    end
  end

  assign out_valid     = ctl_p2.vld;
  assign out_ins       = ctl_p2.ins;
  assign out_result    = ctl_p2.load ? mem_data : res_p2;
  assign out_ovf_mod   = ovf_p2;
  assign out_take_jump = ctl_p2.take_jump;
  assign busy          = vld_p1 || ctl_p2.vld;

endmodule

// File: tb/tb_vec_alu_pipe.sv
// Directed table-driven bench for vec_alu_pipe (WIDTH=16, LANES=4), plus streaming,
// back-pressure and reset-mid-divide sequences.
module tb_vec_alu_pipe;

  localparam int WIDTH = 16;
  localparam int LANES = 4;
  localparam int PC_W  = 16;
`ifdef ALU_ITER_DIV_EN
  localparam int DIV_LAT = WIDTH + 1;
`else
  localparam int DIV_LAT = 1;
`endif
  localparam logic [63:0] MEMX = 64'h4444_3333_2222_BEEF;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   in_valid, in_ready, out_valid, out_ready, out_take_jump, busy;
  logic [PC_W-1:0]        in_pc;
  logic [15:0]            in_ins, out_ins;
  logic [LANES*WIDTH-1:0] in_op1, in_op2, mem_data, out_result, out_ovf_mod;

  vec_alu_pipe #(.WIDTH(WIDTH), .LANES(LANES), .PC_W(PC_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_ins(in_ins), .in_op1(in_op1), .in_op2(in_op2), .mem_data(mem_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ins(out_ins),
    .out_result(out_result), .out_ovf_mod(out_ovf_mod), .out_take_jump(out_take_jump),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] ins;
    logic [15:0] pc;
    logic [63:0] op1;
    logic [63:0] op2;
    logic [63:0] mem;
    logic [63:0] res;
    logic [63:0] ovf;
    logic        jmp;
    int          lat;
  } vec_t;

  int chk = 0;
  int err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    int lows;
    @(negedge clk);
    in_valid = 1'b1; in_ins = v.ins; in_pc = v.pc;
    in_op1 = v.op1; in_op2 = v.op2; mem_data = v.mem;
    check({v.name, "_in_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat  = 0;
    lows = 0;
    while (!out_valid && lat < 64) begin
      if (!in_ready) lows++;
      @(posedge clk);
      lat++;
      #1;
    end
    check({v.name, "_valid"}, 64'(out_valid), 64'd1);
    check({v.name, "_latency"}, 64'(lat), 64'(v.lat));
    check({v.name, "_ready_low"}, 64'(lows), 64'(v.lat - 1));
    check({v.name, "_ins"}, 64'(out_ins), 64'(v.ins));
    check({v.name, "_result"}, out_result, v.res);
    check({v.name, "_ovf_mod"}, out_ovf_mod, v.ovf);
    check({v.name, "_jump"}, 64'(out_take_jump), 64'(v.jmp));
  endtask

  vec_t        tbl [18];
  logic [63:0] s_exp [4];
  logic [15:0] sx, sy, sz;

  initial begin
    tbl[0]  = '{"add",   16'h0000, 16'h0000, 64'hFFFF_0003_0002_0001, 64'h0001_0001_0001_0001, MEMX,
                64'h0000_0004_0003_0002, 64'h0, 1'b0, 1};
    tbl[1]  = '{"sub",   16'h1000, 16'h0000, 64'h000A_0000_0005_0009, 64'h0003_0001_0005_0004, MEMX,
                64'h0007_FFFF_0000_0005, 64'h0, 1'b0, 1};
    tbl[2]  = '{"mul",   16'h2000, 16'h0000, 64'h0000_0003_FFFF_1234, 64'h0007_0005_FFFF_0100, MEMX,
                64'h0000_000F_0001_3400, 64'h0000_0000_FFFE_0012, 1'b0, 1};
    tbl[3]  = '{"div",   16'h3000, 16'h0000, 64'h0007_FFFF_0005_0064, 64'h0009_0001_0000_0007, MEMX,
                64'h0000_FFFF_FFFF_000E, 64'h0007_0000_0005_0002, 1'b0, DIV_LAT};
    tbl[4]  = '{"dot",   16'hE000, 16'h0000, 64'h0004_0003_0002_0001, 64'h0008_0007_0006_0005, MEMX,
                64'h0020_0015_000C_0046, 64'h0, 1'b0, 1};
    tbl[5]  = '{"jz_t",  16'h6000, 16'h0010, 64'h0005_0005_0005_0000, 64'h0009_0009_0009_0040, MEMX,
                64'h0040, 64'h0, 1'b1, 1};
    tbl[6]  = '{"jz_n",  16'h6000, 16'h0010, 64'h0005_0005_0005_0003, 64'h0009_0009_0009_0040, MEMX,
                64'h0012, 64'h0, 1'b0, 1};
    tbl[7]  = '{"jnz_t", 16'h6010, 16'h0010, 64'h0000_0000_0000_0003, 64'h0009_0009_0009_0040, MEMX,
                64'h0040, 64'h0, 1'b1, 1};
    tbl[8]  = '{"js_t",  16'h6020, 16'h0010, 64'h0000_0000_0000_8000, 64'h0009_0009_0009_0040, MEMX,
                64'h0040, 64'h0, 1'b1, 1};
    tbl[9]  = '{"jns_n", 16'h6030, 16'h0010, 64'h0000_0000_0000_8000, 64'h0009_0009_0009_0040, MEMX,
                64'h0012, 64'h0, 1'b0, 1};
    tbl[10] = '{"jbad",  16'h6050, 16'h0010, 64'h0000_0000_0000_0000, 64'h0009_0009_0009_0040, MEMX,
                64'h0012, 64'h0, 1'b0, 1};
    tbl[11] = '{"movl",  16'h8F80, 16'h0000, 64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222, MEMX,
                64'h0000_0000_0000_FFF8, 64'h0, 1'b0, 1};
    tbl[12] = '{"movh",  16'h9120, 16'h0000, 64'h1111_1111_1111_1111, 64'h5555_5555_5555_ABCD, MEMX,
                64'h0000_0000_0000_12CD, 64'h0, 1'b0, 1};
    tbl[13] = '{"store", 16'h4010, 16'h0000, 64'h0004_0003_0002_0001, 64'h9999_9999_9999_9999, MEMX,
                64'h0004_0003_0002_0001, 64'h0, 1'b0, 1};
    tbl[14] = '{"vst",   16'hD010, 16'h0000, 64'hDEAD_BEEF_CAFE_F00D, 64'h9999_9999_9999_9999, MEMX,
                64'hDEAD_BEEF_CAFE_F00D, 64'h0, 1'b0, 1};
    tbl[15] = '{"undef", 16'h5000, 16'h0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234_1234_1234_1234, MEMX,
                64'h0, 64'h0, 1'b0, 1};
    tbl[16] = '{"ld",    16'h7000, 16'h0000, 64'h0000_0000_0000_0001, 64'h0000_0000_0000_0001, MEMX,
                MEMX, 64'h0, 1'b0, 1};
    tbl[17] = '{"vld",   16'hC000, 16'h0000, 64'h0000_0000_0000_0001, 64'h0000_0000_0000_0001,
                64'h0102_0304_0506_0708, 64'h0102_0304_0506_0708, 64'h0, 1'b0, 1};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_pc = '0; in_ins = '0; in_op1 = '0; in_op2 = '0; mem_data = MEMX;
    repeat (2) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_out_ins", 64'(out_ins), 64'd0);
    check("rst_out_result", out_result, 64'd0);
    check("rst_out_ovf_mod", out_ovf_mod, 64'd0);
    check("rst_take_jump", 64'(out_take_jump), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    rst = 1'b0;

    for (int i = 0; i < 18; i++) run_vec(tbl[i]);

    // Back-to-back adds: one result per cycle, two cycles behind the inputs.
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k >= 2) begin
        check("stream_valid", 64'(out_valid), 64'd1);
        check("stream_result", out_result, s_exp[k-2]);
      end
      if (k < 4) begin
        sx = 16'(k * 100);
        sy = 16'(k + 7);
        sz = 16'(k * 100 + k + 7);
        in_valid = 1'b1; in_ins = 16'h0000;
        in_op1 = {4{sx}}; in_op2 = {4{sy}};
        s_exp[k] = {4{sz}};
        check("stream_in_ready", 64'(in_ready), 64'd1);
      end else begin
        in_valid = 1'b0;
      end
    end

    // Back-pressure: a load held in E2 while two adds queue behind it.
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1; in_ins = 16'h7000; in_op1 = '0; in_op2 = '0; mem_data = MEMX;
    @(negedge clk);
    in_ins = 16'h0000; in_op1 = {4{16'd1000}}; in_op2 = {4{16'd1}};
    @(negedge clk);
    in_op1 = {4{16'd2000}}; in_op2 = {4{16'd2}};
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall_valid", 64'(out_valid), 64'd1);
      check("stall_result", out_result, MEMX);
      check("stall_ins", 64'(out_ins), 64'h7000);
      check("stall_in_ready", 64'(in_ready), 64'd0);
      check("stall_busy", 64'(busy), 64'd1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("drain_a_valid", 64'(out_valid), 64'd1);
    check("drain_a_result", out_result, {4{16'd1001}});
    in_valid = 1'b0;
    @(negedge clk);
    check("drain_b_valid", 64'(out_valid), 64'd1);
    check("drain_b_result", out_result, {4{16'd2002}});
    @(negedge clk);
    check("drain_empty_valid", 64'(out_valid), 64'd0);
    check("drain_empty_busy", 64'(busy), 64'd0);

    // Reset arriving while a divide sits in E1.
    @(negedge clk);
    in_valid = 1'b1; in_ins = tbl[3].ins; in_op1 = tbl[3].op1; in_op2 = tbl[3].op2;
    @(posedge clk);
    #1 in_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("rst_div_out_valid", 64'(out_valid), 64'd0);
    check("rst_div_busy", 64'(busy), 64'd0);
    check("rst_div_result", out_result, 64'd0);
    check("rst_div_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    run_vec(tbl[1]);
    run_vec(tbl[3]);

    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end

endmodule
